// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises rx, detects the start edge, samples each bit at mid-period
// and emits one byte per frame with a single-cycle valid strobe or a framing-error strobe.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter int unsigned CNT_W        = 11
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  // Terminal counts: mid start bit, then one full bit period per data/stop bit.
  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             rx_meta;
  logic             rx_s;

  // Two-stage synchroniser, preset to the idle-high line level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with registered strobes, busy and data.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data_out  <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        StIdle: begin
          if (!rx_s) begin
            state <= StStart;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        StStart: begin
          if (cnt == HalfLast) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= StData;
              idx   <= '0;
            end else begin
              // Too short to be a start bit: treat as a glitch.
              state <= StIdle;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StData: begin
          if (cnt == BitLast) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (idx == 3'd7) begin
              state <= StStop;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StStop: begin
          if (cnt == BitLast) begin
            cnt <= '0;
            if (rx_s) begin
              data_out <= shreg;
              rx_valid <= 1'b1;
              state    <= StIdle;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= StBreak;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StBreak: begin
          // Wait out a held-low line so it cannot re-trigger a start.
          if (rx_s) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte with a 16-clock bit period and an ideal 8N1 sender.
module tb_uart_rx_byte;

  localparam int unsigned Cpb = 16;

  logic       clk_in;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int errors;
  int checks;

  // Last good byte the receiver should be holding.
  logic [7:0] exp_last;

  uart_rx_byte #(
    .CLKS_PER_BIT(Cpb),
    .CNT_W       (5)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .rx       (rx),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: records every strobe and any protocol violation of the strobes.
  logic [7:0]  got_q[$];
  int unsigned tv_q[$];
  int          vcnt = 0;
  int          fcnt = 0;
  int          viol = 0;
  logic        prev_v = 1'b0;
  logic        prev_f = 1'b0;
  always @(negedge clk_in) begin
    if (rx_valid) begin
      got_q.push_back(data_out);
      tv_q.push_back(cyc);
      vcnt = vcnt + 1;
    end
    if (frame_err) fcnt = fcnt + 1;
    if ((rx_valid && frame_err) || (rx_valid && prev_v) || (frame_err && prev_f)) viol = viol + 1;
    prev_v = rx_valid;
    prev_f = frame_err;
  end

  task automatic align();
    @(posedge clk_in);
    #1;
  endtask

  // Ideal sender: bit period p100/100 clocks, edges rounded to whole clocks. Sends the first
  // nbits of {stop, data, start}. Must be called aligned at posedge+1; returns aligned.
  task automatic send_frame(input logic [7:0] d, input int p100, input logic stop,
                            input int nbits);
    logic [9:0] frame;
    int len;
    frame = {stop, d, 1'b0};
    for (int j = 0; j < nbits; j++) begin
      rx  = frame[j];
      len = ((j + 1) * p100 + 50) / 100 - (j * p100 + 50) / 100;
      repeat (len) @(posedge clk_in);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    #3;
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b rx_valid=%b frame_err=%b, want 000", busy, rx_valid,
               frame_err);
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: data_out=%h, want 00", data_out);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (100) @(posedge clk_in);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: busy=%b, want 0", busy);
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL idle_data: data_out=%h, want 00", data_out);
    end
    checks++;
    if (vcnt != 0 || fcnt != 0) begin
      errors++;
      $display("FAIL idle_strobes: rx_valid pulses=%0d frame_err pulses=%0d, want 0 0", vcnt,
               fcnt);
    end
    exp_last = 8'h00;
  endtask

  task automatic test_single();
    int v0;
    int unsigned t0;
    align();
    v0 = vcnt;
    t0 = cyc;
    send_frame(8'hA5, 1600, 1'b1, 10);
    rx = 1'b1;
    repeat (30) @(posedge clk_in);
    #1;
    checks++;
    if (vcnt - v0 != 1) begin
      errors++;
      $display("FAIL single_count: pulses=%0d, want 1", vcnt - v0);
    end else begin
      checks++;
      if (got_q[got_q.size() - 1] !== 8'hA5) begin
        errors++;
        $display("FAIL single_data: got %h, want a5", got_q[got_q.size() - 1]);
      end
      // Mid-stop is 9.5 bit periods after the edge, plus 2 sync stages and 1 registered strobe.
      checks++;
      if (tv_q[tv_q.size() - 1] - t0 != (19 * Cpb) / 2 + 3) begin
        errors++;
        $display("FAIL single_latency: %0d clk, want %0d", tv_q[tv_q.size() - 1] - t0,
                 (19 * Cpb) / 2 + 3);
      end
    end
    checks++;
    if (busy !== 1'b0 || data_out !== 8'hA5) begin
      errors++;
      $display("FAIL single_after: busy=%b data_out=%h, want 0 a5", busy, data_out);
    end
    exp_last = 8'hA5;
  endtask

  task automatic test_glitch();
    int v0;
    int f0;
    align();
    v0 = vcnt;
    f0 = fcnt;
    rx = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    rx = 1'b1;
    repeat (6) @(posedge clk_in);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_hi: busy=%b, want 1", busy);
    end
    @(posedge clk_in);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_lo: busy=%b, want 0", busy);
    end
    repeat (200) @(posedge clk_in);
    #1;
    checks++;
    if (vcnt != v0 || fcnt != f0 || data_out !== exp_last) begin
      errors++;
      $display("FAIL glitch_quiet: pulses=%0d errs=%0d data=%h, want 0 0 %h", vcnt - v0,
               fcnt - f0, data_out, exp_last);
    end
  endtask

  task automatic test_frame_err();
    int v0;
    int f0;
    align();
    v0 = vcnt;
    f0 = fcnt;
    send_frame(8'h3C, 1600, 1'b0, 10);
    repeat (40) @(posedge clk_in);
    #1;
    checks++;
    if (fcnt - f0 != 1 || vcnt != v0) begin
      errors++;
      $display("FAIL ferr_strobes: frame_err=%0d rx_valid=%0d, want 1 0", fcnt - f0, vcnt - v0);
    end
    checks++;
    if (data_out !== exp_last) begin
      errors++;
      $display("FAIL ferr_data: data_out=%h, want %h", data_out, exp_last);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy_held: busy=%b, want 1", busy);
    end
    rx = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy_sync: busy=%b, want 1", busy);
    end
    @(posedge clk_in);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_busy_release: busy=%b, want 0", busy);
    end
    repeat (100) @(posedge clk_in);
    #1;
    checks++;
    if (fcnt - f0 != 1 || vcnt != v0) begin
      errors++;
      $display("FAIL ferr_no_retrigger: frame_err=%0d rx_valid=%0d, want 1 0", fcnt - f0,
               vcnt - v0);
    end
  endtask

  // Three frames, zero idle gap, at nominal rate and at both edges of the rate tolerance.
  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    int rates[3];
    int base;
    exp_b = '{8'h00, 8'hFF, 8'h81};
    rates = '{1600, 1536, 1664};
    for (int r = 0; r < 3; r++) begin
      align();
      base = got_q.size();
      for (int k = 0; k < 3; k++) send_frame(exp_b[k], rates[r], 1'b1, 10);
      rx = 1'b1;
      repeat (40) @(posedge clk_in);
      #1;
      checks++;
      if (got_q.size() - base != 3) begin
        errors++;
        $display("FAIL b2b_count rate=%0d: pulses=%0d, want 3", rates[r], got_q.size() - base);
      end else begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (got_q[base + k] !== exp_b[k]) begin
            errors++;
            $display("FAIL b2b_data rate=%0d idx=%0d: got %h, want %h", rates[r], k,
                     got_q[base + k], exp_b[k]);
          end
        end
      end
    end
    exp_last = 8'h81;
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL strobe_rules: violations=%0d, want 0", viol);
    end
  endtask

  // Random bytes at random in-tolerance rates and random idle gaps; the model is a byte queue.
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int base;
    int p100;
    int gap;
    align();
    base = got_q.size();
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom);
      p100 = 1536 + 64 * int'($urandom_range(0, 2));
      gap  = int'($urandom_range(0, 8));
      send_frame(b, p100, 1'b1, 10);
      exp_q.push_back(b);
      rx = 1'b1;
      repeat (gap) @(posedge clk_in);
      #1;
    end
    repeat (40) @(posedge clk_in);
    #1;
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: pulses=%0d, want %0d", got_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (got_q[base + k] !== exp_q[k]) begin
          errors++;
          $display("FAIL rand_data idx=%0d: got %h, want %h", k, got_q[base + k], exp_q[k]);
        end
      end
      exp_last = exp_q[exp_q.size() - 1];
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int v0;
    int f0;
    d = 8'h5A;
    align();
    v0 = vcnt;
    f0 = fcnt;
    send_frame(d, 1600, 1'b1, 5);
    rx = d[4];
    repeat (8) @(posedge clk_in);
    #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async: busy=%b data_out=%h, want 0 00", busy, data_out);
    end
    repeat (3) @(posedge clk_in);
    #1;
    rx    = 1'b1;
    rst_n = 1'b1;
    exp_last = 8'h00;
    repeat (200) @(posedge clk_in);
    #1;
    checks++;
    if (vcnt != v0 || fcnt != f0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_aborted: rx_valid=%0d frame_err=%0d busy=%b, want 0 0 0", vcnt - v0,
               fcnt - f0, busy);
    end
    send_frame(8'h12, 1600, 1'b1, 10);
    rx = 1'b1;
    repeat (30) @(posedge clk_in);
    #1;
    checks++;
    if (vcnt - v0 != 1) begin
      errors++;
      $display("FAIL midrst_count: pulses=%0d, want 1", vcnt - v0);
    end
    checks++;
    if (data_out !== 8'h12) begin
      errors++;
      $display("FAIL midrst_data: data_out=%h, want 12", data_out);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
